// File: rtl/receptor_pedidos_serial_pkg.sv
// Shared constants and state encodings for the SmartCargo serial request front-end.
// Optional build macro: SERIAL_PARIDADE_EN (8E1 framing; default 8N1).
package smart_cargo_pkg;

    localparam int unsigned LARGURA_ANDAR = 2;

    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_D  = 8'h44;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [3:0] {
        ESPERA_O   = 4'd0,
        LE_ORIG    = 4'd1,
        ESPERA_D   = 4'd2,
        LE_DEST    = 4'd3,
        ESPERA_FIM = 4'd4
    } estado_parser_t;

    typedef enum logic [2:0] {
        RX_OCIOSO,
        RX_INICIO,
        RX_DADOS,
        RX_PARIDADE,
        RX_PARADA,
        RX_FIM
    } estado_rx_t;

    // '0'..'3' share the upper six bits of ASCII_0
    function automatic logic eh_andar(input logic [7:0] b);
        return b[7:2] == ASCII_0[7:2];
    endfunction

endpackage

// File: rtl/receptor_pedidos_serial_rx.sv
// rx_serial_bytes: synchronized UART byte receiver with mid-bit sampling.
// SERIAL_PARIDADE_EN adds an even-parity bit after bit 7.
module rx_serial_bytes
    import smart_cargo_pkg::*;
#(
    parameter int unsigned DIV = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_ok,
    output logic [7:0] dado,
    output logic       erro_quadro
);

    localparam int unsigned CW = $clog2(DIV);

    estado_rx_t    est_q, est_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    nbit_q, nbit_d;
    logic [7:0]    shift_q, shift_d;
    logic          s1_q, s2_q;
    logic [1:0]    flush_q, flush_d;
    logic          armed_q, armed_d;
    logic          stop_q, stop_d;
    logic          par_ok_q, par_ok_d;
    logic          byte_ok_q, byte_ok_d;
    logic          erro_q, erro_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            est_q     <= RX_OCIOSO;
            cnt_q     <= '0;
            nbit_q    <= '0;
            shift_q   <= '0;
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            flush_q   <= '0;
            armed_q   <= 1'b0;
            stop_q    <= 1'b0;
            par_ok_q  <= 1'b1;
            byte_ok_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            est_q     <= est_d;
            cnt_q     <= cnt_d;
            nbit_q    <= nbit_d;
            shift_q   <= shift_d;
            s1_q      <= rx;
            s2_q      <= s1_q;
            flush_q   <= flush_d;
            armed_q   <= armed_d;
            stop_q    <= stop_d;
            par_ok_q  <= par_ok_d;
            byte_ok_q <= byte_ok_d;
            erro_q    <= erro_d;
        end
    end

    // Starts arm only once the flushed synchronizer has shown a genuinely high line,
    // so a line held low across reset or after a break cannot fake a start bit.
    always_comb begin
        est_d     = est_q;
        cnt_d     = cnt_q + 1'b1;
        nbit_d    = nbit_q;
        shift_d   = shift_q;
        flush_d   = {flush_q[0], 1'b1};
        armed_d   = armed_q;
        stop_d    = stop_q;
        par_ok_d  = par_ok_q;
        byte_ok_d = 1'b0;
        erro_d    = 1'b0;
        case (est_q)
            RX_OCIOSO: begin
                cnt_d = '0;
                if (flush_q[1] && s2_q) armed_d = 1'b1;
                if (armed_q && !s2_q) begin
                    est_d    = RX_INICIO;
                    armed_d  = 1'b0;
                    par_ok_d = 1'b1;
                end
            end
            RX_INICIO: if (cnt_q == CW'(DIV/2 - 1)) begin
                cnt_d  = '0;
                nbit_d = '0;
                est_d  = s2_q ? RX_OCIOSO : RX_DADOS;
            end
            RX_DADOS: if (cnt_q == CW'(DIV - 1)) begin
                cnt_d   = '0;
                shift_d = {s2_q, shift_q[7:1]};
                nbit_d  = nbit_q + 1'b1;
                if (nbit_q == 3'd7) begin
`ifdef SERIAL_PARIDADE_EN
                    est_d = RX_PARIDADE;
`else
                    est_d = RX_PARADA;
`endif
                end
            end
`ifdef SERIAL_PARIDADE_EN
            RX_PARIDADE: if (cnt_q == CW'(DIV - 1)) begin
                cnt_d    = '0;
                par_ok_d = (s2_q == ^shift_q);
                est_d    = RX_PARADA;
            end
`endif
            RX_PARADA: if (cnt_q == CW'(DIV - 1)) begin
                cnt_d  = '0;
                stop_d = s2_q;
                est_d  = RX_FIM;
            end
            RX_FIM: begin
                cnt_d     = '0;
                byte_ok_d = stop_q & par_ok_q;
                erro_d    = ~(stop_q & par_ok_q);
                est_d     = RX_OCIOSO;
            end
            default: begin
                cnt_d = '0;
                est_d = RX_OCIOSO;
            end
        endcase
    end

    assign byte_ok     = byte_ok_q;
    assign erro_quadro = erro_q;
    assign dado        = shift_q;

endmodule

// File: rtl/receptor_pedidos_serial.sv
// Decodes "O<orig>D<dest>\n" serial frames into a validated floor pair with valid/accept handshake.
// SERIAL_PARIDADE_EN selects 8E1 framing in the byte receiver.
module receptor_pedidos_serial
    import smart_cargo_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     RX,
    input  logic                     pedido_aceito,
    output logic                     pedido_valido,
    output logic [LARGURA_ANDAR-1:0] origem,
    output logic [LARGURA_ANDAR-1:0] destino,
    output logic                     erro_pedido,
    output logic                     pedido_perdido,
    output logic [3:0]               db_estado,
    output logic [7:0]               db_ultimo_byte
);

    localparam int unsigned DIV = CLK_HZ / BAUD;

    logic       byte_ok, erro_quadro;
    logic [7:0] dado;

    rx_serial_bytes #(.DIV(DIV)) u_rx (
        .clock       (clock),
        .reset       (reset),
        .rx          (RX),
        .byte_ok     (byte_ok),
        .dado        (dado),
        .erro_quadro (erro_quadro)
    );

    estado_parser_t           estado_q, estado_d;
    logic [LARGURA_ANDAR-1:0] orig_tmp_q, orig_tmp_d, dest_tmp_q, dest_tmp_d;
    logic [LARGURA_ANDAR-1:0] origem_q, origem_d, destino_q, destino_d;
    logic                     valido_q, valido_d, erro_q, erro_d, perdido_q, perdido_d;
    logic [7:0]               ultimo_q, ultimo_d;
    logic                     inesperado;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= ESPERA_O;
            orig_tmp_q <= '0;
            dest_tmp_q <= '0;
            origem_q   <= '0;
            destino_q  <= '0;
            valido_q   <= 1'b0;
            erro_q     <= 1'b0;
            perdido_q  <= 1'b0;
            ultimo_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            orig_tmp_q <= orig_tmp_d;
            dest_tmp_q <= dest_tmp_d;
            origem_q   <= origem_d;
            destino_q  <= destino_d;
            valido_q   <= valido_d;
            erro_q     <= erro_d;
            perdido_q  <= perdido_d;
            ultimo_q   <= ultimo_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        orig_tmp_d = orig_tmp_q;
        dest_tmp_d = dest_tmp_q;
        origem_d   = origem_q;
        destino_d  = destino_q;
        valido_d   = valido_q & ~pedido_aceito;
        erro_d     = 1'b0;
        perdido_d  = 1'b0;
        ultimo_d   = ultimo_q;
        inesperado = 1'b0;
        if (erro_quadro) begin
            erro_d   = 1'b1;
            estado_d = ESPERA_O;
        end else if (byte_ok) begin
            ultimo_d = dado;
            case (estado_q)
                ESPERA_O: if (dado == ASCII_O) estado_d = LE_ORIG;
                LE_ORIG: if (eh_andar(dado)) begin
                    orig_tmp_d = dado[LARGURA_ANDAR-1:0];
                    estado_d   = ESPERA_D;
                end else inesperado = 1'b1;
                ESPERA_D: if (dado == ASCII_D) estado_d = LE_DEST;
                    else inesperado = 1'b1;
                LE_DEST: if (eh_andar(dado)) begin
                    dest_tmp_d = dado[LARGURA_ANDAR-1:0];
                    estado_d   = ESPERA_FIM;
                end else inesperado = 1'b1;
                ESPERA_FIM: if (dado == ASCII_LF) begin
                    estado_d = ESPERA_O;
                    if (orig_tmp_q == dest_tmp_q) begin
                        erro_d = 1'b1;
                    end else if (!valido_q || pedido_aceito) begin
                        // a same-cycle accept frees the slot for the new request
                        valido_d  = 1'b1;
                        origem_d  = orig_tmp_q;
                        destino_d = dest_tmp_q;
                    end else begin
                        perdido_d = 1'b1;
                    end
                end else inesperado = 1'b1;
                default: estado_d = ESPERA_O;
            endcase
            if (inesperado) begin
                erro_d   = 1'b1;
                estado_d = (dado == ASCII_O) ? LE_ORIG : ESPERA_O;
            end
        end
    end

    assign pedido_valido  = valido_q;
    assign origem         = origem_q;
    assign destino        = destino_q;
    assign erro_pedido    = erro_q;
    assign pedido_perdido = perdido_q;
    assign db_estado      = estado_q;
    assign db_ultimo_byte = ultimo_q;

endmodule

// File: tb/tb_receptor_pedidos_serial.sv
// Directed self-checking bench for receptor_pedidos_serial, 8N1 build, scaled baud (DIV = 16).
module tb_receptor_pedidos_serial;

    localparam int unsigned CLK_HZ = 160;
    localparam int unsigned BAUD   = 10;
    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int unsigned LAT    = 2 + DIV/2 + 9*DIV + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       RX = 1'b1;
    logic       pedido_aceito = 1'b0;
    logic       pedido_valido;
    logic [1:0] origem, destino;
    logic       erro_pedido, pedido_perdido;
    logic [3:0] db_estado;
    logic [7:0] db_ultimo_byte;

    int n_checks = 0;
    int n_fails  = 0;
    int n_erro   = 0;
    int n_perdido = 0;

    receptor_pedidos_serial #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clock          (clock),
        .reset          (reset),
        .RX             (RX),
        .pedido_aceito  (pedido_aceito),
        .pedido_valido  (pedido_valido),
        .origem         (origem),
        .destino        (destino),
        .erro_pedido    (erro_pedido),
        .pedido_perdido (pedido_perdido),
        .db_estado      (db_estado),
        .db_ultimo_byte (db_ultimo_byte)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (erro_pedido)    n_erro++;
        if (pedido_perdido) n_perdido++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge clock); #1 RX = 1'b0;
        repeat (DIV) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            #1 RX = b[i];
            repeat (DIV) @(posedge clock);
        end
        #1 RX = stop_bit;
        repeat (DIV) @(posedge clock);
        #1 RX = 1'b1;
        repeat (4) @(posedge clock);
    endtask

    task automatic send_frame(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic aceitar;
        @(posedge clock); #1 pedido_aceito = 1'b1;
        @(posedge clock); #1 pedido_aceito = 1'b0;
    endtask

    // Sends the LF terminator and checks pedido_valido one cycle before and at the exact latency
    task automatic term_temporizado(input logic pulso_aceito, input logic valido_antes,
                                    input logic [4:0] esperado);
        fork
            send_byte(8'h0A, 1'b1);
            begin
                @(posedge clock); #2;
                repeat (LAT) @(posedge clock);
                #1;
                n_checks++;
                if (pedido_valido !== valido_antes) begin
                    n_fails++;
                    $display("FAIL latencia_antes: got %b required %b", pedido_valido, valido_antes);
                end
                if (pulso_aceito) pedido_aceito = 1'b1;
                @(posedge clock); #1;
                pedido_aceito = 1'b0;
                n_checks++;
                if ({pedido_valido, origem, destino} !== esperado) begin
                    n_fails++;
                    $display("FAIL latencia_pedido: got %b required %b",
                             {pedido_valido, origem, destino}, esperado);
                end
            end
        join
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({pedido_valido, origem, destino, erro_pedido, pedido_perdido, db_estado, db_ultimo_byte} !== 19'd0) begin
            n_fails++;
            $display("FAIL reset_saidas: got %h required 0",
                     {pedido_valido, origem, destino, erro_pedido, pedido_perdido, db_estado, db_ultimo_byte});
        end
        reset = 1'b0;
        repeat (4) @(posedge clock);
    endtask

    task automatic test_pedido_basico;
        int e0 = n_erro;
        int p0 = n_perdido;
        send_frame("O1D3");
        term_temporizado(1'b0, 1'b0, 5'b1_01_11);
        repeat (20) @(posedge clock);
        #1;
        n_checks++;
        if ({pedido_valido, origem, destino} !== 5'b1_01_11) begin
            n_fails++;
            $display("FAIL basico_mantido: got %b required %b", {pedido_valido, origem, destino}, 5'b1_01_11);
        end
        n_checks++;
        if (db_ultimo_byte !== 8'h0A) begin
            n_fails++;
            $display("FAIL basico_ultimo_byte: got %h required 0a", db_ultimo_byte);
        end
        aceitar();
        n_checks++;
        if (pedido_valido !== 1'b0) begin
            n_fails++;
            $display("FAIL basico_aceito: got %b required 0", pedido_valido);
        end
        n_checks++;
        if ((n_erro - e0) !== 0 || (n_perdido - p0) !== 0) begin
            n_fails++;
            $display("FAIL basico_pulsos: got erro=%0d perdido=%0d required 0 0", n_erro - e0, n_perdido - p0);
        end
    endtask

    task automatic test_mesmo_andar;
        int e0 = n_erro;
        aceitar();
        n_checks++;
        if (pedido_valido !== 1'b0) begin
            n_fails++;
            $display("FAIL aceito_ocioso: got %b required 0", pedido_valido);
        end
        send_frame("O2D2\n");
        n_checks++;
        if ((n_erro - e0) !== 1) begin
            n_fails++;
            $display("FAIL mesmo_andar_erro: got %0d pulses required 1", n_erro - e0);
        end
        n_checks++;
        if (pedido_valido !== 1'b0) begin
            n_fails++;
            $display("FAIL mesmo_andar_valido: got %b required 0", pedido_valido);
        end
    endtask

    task automatic test_perdido;
        int e0 = n_erro;
        int p0 = n_perdido;
        send_frame("O0D1\n");
        send_frame("O3D0\n");
        n_checks++;
        if ({pedido_valido, origem, destino} !== 5'b1_00_01) begin
            n_fails++;
            $display("FAIL perdido_mantido: got %b required %b", {pedido_valido, origem, destino}, 5'b1_00_01);
        end
        n_checks++;
        if ((n_perdido - p0) !== 1 || (n_erro - e0) !== 0) begin
            n_fails++;
            $display("FAIL perdido_pulsos: got perdido=%0d erro=%0d required 1 0", n_perdido - p0, n_erro - e0);
        end
        aceitar();
    endtask

    task automatic test_back_to_back;
        int p0;
        send_frame("O3D1\n");
        p0 = n_perdido;
        send_frame("O1D2");
        term_temporizado(1'b1, 1'b1, 5'b1_01_10);
        n_checks++;
        if ((n_perdido - p0) !== 0) begin
            n_fails++;
            $display("FAIL simultaneo_perdido: got %0d pulses required 0", n_perdido - p0);
        end
        aceitar();
    endtask

    task automatic test_resync;
        int e0 = n_erro;
        send_frame("O1XO2D0\n");
        n_checks++;
        if ((n_erro - e0) !== 1) begin
            n_fails++;
            $display("FAIL resync_erro: got %0d pulses required 1", n_erro - e0);
        end
        n_checks++;
        if ({pedido_valido, origem, destino} !== 5'b1_10_00) begin
            n_fails++;
            $display("FAIL resync_pedido: got %b required %b", {pedido_valido, origem, destino}, 5'b1_10_00);
        end
        aceitar();
    endtask

    task automatic test_glitch;
        int e0 = n_erro;
        int p0 = n_perdido;
        @(posedge clock); #1 RX = 1'b0;
        repeat (DIV * 3 / 10) @(posedge clock);
        #1 RX = 1'b1;
        repeat (3 * DIV) @(posedge clock);
        #1;
        n_checks++;
        if (db_ultimo_byte !== 8'h0A || db_estado !== 4'd0) begin
            n_fails++;
            $display("FAIL glitch_estado: got byte=%h estado=%0d required 0a 0", db_ultimo_byte, db_estado);
        end
        n_checks++;
        if ((n_erro - e0) !== 0 || (n_perdido - p0) !== 0 || pedido_valido !== 1'b0) begin
            n_fails++;
            $display("FAIL glitch_pulsos: got erro=%0d perdido=%0d valido=%b required 0 0 0",
                     n_erro - e0, n_perdido - p0, pedido_valido);
        end
    endtask

    task automatic test_stop_invalido;
        int e0 = n_erro;
        send_byte(8'h4F, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (2 * DIV) @(posedge clock);
        #1;
        n_checks++;
        if ((n_erro - e0) !== 1) begin
            n_fails++;
            $display("FAIL quadro_erro: got %0d pulses required 1", n_erro - e0);
        end
        n_checks++;
        if (db_ultimo_byte !== 8'h4F || db_estado !== 4'd0) begin
            n_fails++;
            $display("FAIL quadro_estado: got byte=%h estado=%0d required 4f 0", db_ultimo_byte, db_estado);
        end
    endtask

    task automatic test_reset_meio;
        int e0 = n_erro;
        int p0 = n_perdido;
        send_frame("O2D1\n");
        send_frame("O1D");
        n_checks++;
        if (db_estado !== 4'd3 || pedido_valido !== 1'b1) begin
            n_fails++;
            $display("FAIL meio_quadro_estado: got estado=%0d valido=%b required 3 1", db_estado, pedido_valido);
        end
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if ({pedido_valido, origem, destino, erro_pedido, pedido_perdido, db_estado, db_ultimo_byte} !== 19'd0) begin
            n_fails++;
            $display("FAIL reset_meio_saidas: got %h required 0",
                     {pedido_valido, origem, destino, erro_pedido, pedido_perdido, db_estado, db_ultimo_byte});
        end
        @(posedge clock); #1 reset = 1'b0;
        repeat (4) @(posedge clock);
        send_frame("O0D2\n");
        n_checks++;
        if ({pedido_valido, origem, destino} !== 5'b1_00_10) begin
            n_fails++;
            $display("FAIL pos_reset_pedido: got %b required %b", {pedido_valido, origem, destino}, 5'b1_00_10);
        end
        n_checks++;
        if ((n_erro - e0) !== 0 || (n_perdido - p0) !== 0) begin
            n_fails++;
            $display("FAIL reset_meio_pulsos: got erro=%0d perdido=%0d required 0 0", n_erro - e0, n_perdido - p0);
        end
    endtask

    initial begin
        test_reset();
        test_pedido_basico();
        test_mesmo_andar();
        test_perdido();
        test_back_to_back();
        test_resync();
        test_glitch();
        test_stop_invalido();
        test_reset_meio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
